// File: rtl/nco_freq_ctrl_if.sv
// ---------------------------------------------------------------------------
// nco_freq_ctrl_if
// Bundles the UART byte stream, the DAC sample strobe and the controller
// outputs that go to the NCO / LED display.
//   sample_ce  : one-cycle sample strobe (master -> slave)
//   rx_valid   : one-cycle byte valid from UART RX (master -> slave)
//   rx_byte    : received byte (master -> slave)
//   phase_inc  : committed phase increment (slave -> master)
//   busy       : raw-load in progress (slave -> master)
//   cmd_err    : one-cycle error pulse (slave -> master)
//   last_cmd   : last accepted command byte (slave -> master)
// ---------------------------------------------------------------------------
interface nco_freq_ctrl_if #(
    parameter int PHASE_WIDTH = 64
);
    logic                   sample_ce;
    logic                   rx_valid;
    logic [7:0]             rx_byte;
    logic [PHASE_WIDTH-1:0] phase_inc;
    logic                   busy;
    logic                   cmd_err;
    logic [7:0]             last_cmd;

    modport master (
        output sample_ce, rx_valid, rx_byte,
        input  phase_inc, busy, cmd_err, last_cmd
    );

    modport slave (
        input  sample_ce, rx_valid, rx_byte,
        output phase_inc, busy, cmd_err, last_cmd
    );
endinterface

// File: rtl/nco_freq_ctrl.sv
// ---------------------------------------------------------------------------
// nco_freq_ctrl
// Decodes UART command bytes into a target NCO phase increment (presets,
// saturating +/-1 kHz and +/-100 Hz steps, mute, raw 64-bit load) and commits
// the target to the NCO only on sample strobes.
// Optional feature: define NCO_SWEEP_EN to enable the autonomous sweep ('s').
// Ports:
//   clk    : system clock
//   arst_n : asynchronous active-low reset
//   bus    : nco_freq_ctrl_if.slave (sample_ce, rx_valid, rx_byte in;
//            phase_inc, busy, cmd_err, last_cmd out)
// ---------------------------------------------------------------------------
module nco_freq_ctrl #(
    parameter int                PHASE_WIDTH = 64,
    parameter logic [PHASE_WIDTH-1:0] INC_100 = 64'd19676527011956855,
    parameter logic [PHASE_WIDTH-1:0] INC_1K  = 64'd196765270119568550,
    parameter logic [PHASE_WIDTH-1:0] INC_5K  = 64'd983826350597842752,
    parameter logic [PHASE_WIDTH-1:0] INC_10K = 64'd1967652701195685505,
    parameter logic [PHASE_WIDTH-1:0] INC_15K = 64'd2951479051793528258,
    parameter logic [PHASE_WIDTH-1:0] INC_MAX = 64'd5902958103587056517,
    parameter int                TIMEOUT_CYC = 4800000,
    parameter int                SWEEP_DIV   = 480
) (
    input  logic            clk,
    input  logic            arst_n,
    nco_freq_ctrl_if.slave  bus
);

    localparam int PW       = PHASE_WIDTH;
    localparam int TW       = $clog2(TIMEOUT_CYC + 1);
    localparam int LAST_IDX = PW / 8 - 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t          r_state,    w_state_nxt;
    logic [PW-1:0]   r_target,   w_target_nxt;
    logic [PW-1:0]   r_shadow,   w_shadow_nxt;
    logic [PW-1:0]   r_phase_inc;
    logic [PW-1:0]   w_shadow_shift;
    logic [3:0]      r_byte_cnt, w_byte_cnt_nxt;
    logic [TW-1:0]   r_tmo_cnt,  w_tmo_cnt_nxt;
    logic            r_busy;
    logic            r_cmd_err,  w_cmd_err_nxt;
    logic [7:0]      r_last_cmd, w_last_cmd_nxt;
    logic            w_accept;

`ifdef NCO_SWEEP_EN
    localparam int DW = $clog2(SWEEP_DIV + 1);
    logic            r_sweep,    w_sweep_nxt;
    logic [DW-1:0]   r_div_cnt,  w_div_cnt_nxt;

    // Sweep step: one 100 Hz step, sawtooth back to 100 Hz past the limit.
    function automatic logic [PW-1:0] sweep_step(input logic [PW-1:0] a);
        logic [PW:0] s;
        s = {1'b0, a} + {1'b0, INC_100};
        if (s > {1'b0, INC_MAX}) begin
            sweep_step = INC_100;
        end else begin
            sweep_step = s[PW-1:0];
        end
    endfunction
`endif

    // Saturating add, clamped to INC_MAX (also catches carry-out).
    function automatic logic [PW-1:0] sat_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
        logic [PW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, INC_MAX}) begin
            sat_add = INC_MAX;
        end else begin
            sat_add = s[PW-1:0];
        end
    endfunction

    // Saturating subtract, floored at zero.
    function automatic logic [PW-1:0] sat_sub(input logic [PW-1:0] a, input logic [PW-1:0] b);
        if (a < b) begin
            sat_sub = {PW{1'b0}};
        end else begin
            sat_sub = a - b;
        end
    endfunction

    // Clamp a raw-loaded value to the upper limit.
    function automatic logic [PW-1:0] clamp_max(input logic [PW-1:0] a);
        if (a > INC_MAX) begin
            clamp_max = INC_MAX;
        end else begin
            clamp_max = a;
        end
    endfunction

    assign w_shadow_shift = {r_shadow[PW-9:0], bus.rx_byte};

    // Next-state, target arithmetic, load shifting and timeout logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_target_nxt   = r_target;
        w_shadow_nxt   = r_shadow;
        w_byte_cnt_nxt = r_byte_cnt;
        w_tmo_cnt_nxt  = r_tmo_cnt;
        w_cmd_err_nxt  = 1'b0;
        w_last_cmd_nxt = r_last_cmd;
        w_accept       = 1'b0;
`ifdef NCO_SWEEP_EN
        w_sweep_nxt    = r_sweep;
        w_div_cnt_nxt  = r_div_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                w_tmo_cnt_nxt = {TW{1'b0}};
                if (bus.rx_valid) begin
                    w_accept = 1'b1;
                    case (bus.rx_byte)
                        8'h61:   w_target_nxt = INC_1K;
                        8'h62:   w_target_nxt = INC_5K;
                        8'h66:   w_target_nxt = INC_10K;
                        8'h67:   w_target_nxt = INC_15K;
                        8'h6d:   w_target_nxt = sat_add(r_target, INC_1K);
                        8'h6e:   w_target_nxt = sat_sub(r_target, INC_1K);
                        8'h70:   w_target_nxt = sat_add(r_target, INC_100);
                        8'h6f:   w_target_nxt = sat_sub(r_target, INC_100);
                        8'h7a:   w_target_nxt = {PW{1'b0}};
                        8'h78: begin
                            w_byte_cnt_nxt = 4'd0;
                            w_shadow_nxt   = {PW{1'b0}};
                            w_state_nxt    = ST_LOAD;
                        end
`ifdef NCO_SWEEP_EN
                        8'h73: begin
                            w_sweep_nxt   = ~r_sweep;
                            w_div_cnt_nxt = {DW{1'b0}};
                        end
`endif
                        default: begin
                            w_accept      = 1'b0;
                            w_cmd_err_nxt = 1'b1;
                        end
                    endcase
                    if (w_accept) begin
                        w_last_cmd_nxt = bus.rx_byte;
                    end else begin
                        w_last_cmd_nxt = r_last_cmd;
                    end
`ifdef NCO_SWEEP_EN
                    // Any accepted command other than 's' ends a sweep.
                    if (w_accept && (bus.rx_byte != 8'h73)) begin
                        w_sweep_nxt   = 1'b0;
                        w_div_cnt_nxt = {DW{1'b0}};
                    end else begin
                        w_sweep_nxt = w_sweep_nxt;
                    end
`endif
                end else begin
`ifdef NCO_SWEEP_EN
                    // Sweep only advances on idle cycles; a command in the same cycle wins.
                    if (r_sweep && bus.sample_ce) begin
                        if (r_div_cnt == DW'(SWEEP_DIV - 1)) begin
                            w_div_cnt_nxt = {DW{1'b0}};
                            w_target_nxt  = sweep_step(r_target);
                        end else begin
                            w_div_cnt_nxt = r_div_cnt + DW'(1);
                        end
                    end else begin
                        w_div_cnt_nxt = r_div_cnt;
                    end
`else
                    w_target_nxt = r_target;
`endif
                end
            end
            ST_LOAD: begin
                if (bus.rx_valid) begin
                    w_shadow_nxt  = w_shadow_shift;
                    w_tmo_cnt_nxt = {TW{1'b0}};
                    if (r_byte_cnt == 4'(LAST_IDX)) begin
                        w_target_nxt   = clamp_max(w_shadow_shift);
                        w_byte_cnt_nxt = 4'd0;
                        w_state_nxt    = ST_IDLE;
                    end else begin
                        w_byte_cnt_nxt = r_byte_cnt + 4'd1;
                    end
                end else if (r_tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    // Counter holds cycles since the last byte minus one.
                    w_tmo_cnt_nxt  = {TW{1'b0}};
                    w_byte_cnt_nxt = 4'd0;
                    w_cmd_err_nxt  = 1'b1;
                    w_state_nxt    = ST_IDLE;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + TW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Controller state, target and output registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state    <= ST_IDLE;
            r_target   <= {PW{1'b0}};
            r_shadow   <= {PW{1'b0}};
            r_byte_cnt <= 4'd0;
            r_tmo_cnt  <= {TW{1'b0}};
            r_busy     <= 1'b0;
            r_cmd_err  <= 1'b0;
            r_last_cmd <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_target   <= w_target_nxt;
            r_shadow   <= w_shadow_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_tmo_cnt  <= w_tmo_cnt_nxt;
            r_busy     <= (w_state_nxt == ST_LOAD);
            r_cmd_err  <= w_cmd_err_nxt;
            r_last_cmd <= w_last_cmd_nxt;
        end
    end

    // Commit the pre-edge target to the NCO on sample strobes only.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_phase_inc <= {PW{1'b0}};
        end else if (bus.sample_ce) begin
            r_phase_inc <= r_target;
        end else begin
            r_phase_inc <= r_phase_inc;
        end
    end

`ifdef NCO_SWEEP_EN
    // Sweep flag and strobe divider.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_sweep   <= 1'b0;
            r_div_cnt <= {DW{1'b0}};
        end else begin
            r_sweep   <= w_sweep_nxt;
            r_div_cnt <= w_div_cnt_nxt;
        end
    end
`endif

    assign bus.phase_inc = r_phase_inc;
    assign bus.busy      = r_busy;
    assign bus.cmd_err   = r_cmd_err;
    assign bus.last_cmd  = r_last_cmd;

endmodule

// File: tb/tb_nco_freq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nco_freq_ctrl
// Table-driven command vectors, hand-written multi-cycle sequences (raw load,
// timeout, same-cycle strobe, reset mid-load, sweep) and a randomized run
// against an arithmetic reference model of the target frequency.
// ---------------------------------------------------------------------------
module tb_nco_freq_ctrl;

    localparam logic [63:0] INC_100 = 64'd19676527011956855;
    localparam logic [63:0] INC_1K  = 64'd196765270119568550;
    localparam logic [63:0] INC_5K  = 64'd983826350597842752;
    localparam logic [63:0] INC_10K = 64'd1967652701195685505;
    localparam logic [63:0] INC_15K = 64'd2951479051793528258;
    localparam logic [63:0] INC_MAX = 64'd5902958103587056517;
    localparam int          TMO     = 40;
    localparam int          SDIV    = 4;

    logic clk;
    logic arst_n;
    int   checks;
    int   errors;

    logic [63:0] m_target;
    logic [7:0]  m_last;

    nco_freq_ctrl_if #(.PHASE_WIDTH(64)) bus_if ();

    nco_freq_ctrl #(
        .PHASE_WIDTH (64),
        .TIMEOUT_CYC (TMO),
        .SWEEP_DIV   (SDIV)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b;
        logic [63:0] exp_phase;
        logic [7:0]  exp_last;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_ce(input logic [7:0] b, input logic ce);
        bus_if.rx_valid  = 1'b1;
        bus_if.rx_byte   = b;
        bus_if.sample_ce = ce;
        @(negedge clk);
        bus_if.rx_valid  = 1'b0;
        bus_if.sample_ce = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        send_ce(b, 1'b0);
    endtask

    task automatic strobe();
        bus_if.sample_ce = 1'b1;
        @(negedge clk);
        bus_if.sample_ce = 1'b0;
    endtask

    function automatic bit is_cmd(input logic [7:0] b);
        return (b == 8'h61) || (b == 8'h62) || (b == 8'h66) || (b == 8'h67) ||
               (b == 8'h6d) || (b == 8'h6e) || (b == 8'h6f) || (b == 8'h70) ||
               (b == 8'h7a) || (b == 8'h78) || (b == 8'h73);
    endfunction

    // Reference model of a single IDLE command; returns 1 for an unknown byte.
    function automatic bit model_cmd(input logic [7:0] b);
        logic [64:0] s;
        model_cmd = 1'b0;
        case (b)
            8'h61: m_target = INC_1K;
            8'h62: m_target = INC_5K;
            8'h66: m_target = INC_10K;
            8'h67: m_target = INC_15K;
            8'h6d: begin s = m_target + INC_1K;  m_target = (s > INC_MAX) ? INC_MAX : s[63:0]; end
            8'h70: begin s = m_target + INC_100; m_target = (s > INC_MAX) ? INC_MAX : s[63:0]; end
            8'h6e: m_target = (m_target < INC_1K)  ? 64'd0 : m_target - INC_1K;
            8'h6f: m_target = (m_target < INC_100) ? 64'd0 : m_target - INC_100;
            8'h7a: m_target = 64'd0;
            default: model_cmd = 1'b1;
        endcase
        if (!model_cmd) m_last = b;
    endfunction

    // Full raw load with small random gaps; model target updated at the end.
    task automatic raw_load(input logic [63:0] v, input bit chk_busy);
        send(8'h78);
        m_last = 8'h78;
        if (chk_busy) chk("load_busy_rise", {63'd0, bus_if.busy}, 64'd1);
        for (int i = 7; i >= 0; i--) begin
            idle($urandom_range(0, 3));
            send(v[i*8 +: 8]);
            if (chk_busy && i != 0) chk("load_busy_mid", {63'd0, bus_if.busy}, 64'd1);
        end
        if (chk_busy) chk("load_busy_fall", {63'd0, bus_if.busy}, 64'd0);
        m_target = (v > INC_MAX) ? INC_MAX : v;
    endtask

    initial begin
        logic [63:0] prev;
        logic [63:0] rv;
        logic [7:0]  b;
        bit          e;
        bit          ce;
        string       cmds;

        checks = 0;
        errors = 0;
        bus_if.sample_ce = 1'b0;
        bus_if.rx_valid  = 1'b0;
        bus_if.rx_byte   = 8'd0;
        arst_n = 1'b0;
        m_target = 64'd0;
        m_last   = 8'd0;
        idle(3);
        chk("rst_phase", bus_if.phase_inc, 64'd0);
        chk("rst_busy", {63'd0, bus_if.busy}, 64'd0);
        chk("rst_err", {63'd0, bus_if.cmd_err}, 64'd0);
        chk("rst_last", {56'd0, bus_if.last_cmd}, 64'd0);
        arst_n = 1'b1;
        idle(2);

        vecs[0]  = '{8'h61, INC_1K,                   8'h61, 1'b0};
        vecs[1]  = '{8'h6d, INC_1K * 64'd2,           8'h6d, 1'b0};
        vecs[2]  = '{8'h70, INC_1K * 64'd2 + INC_100, 8'h70, 1'b0};
        vecs[3]  = '{8'h6f, INC_1K * 64'd2,           8'h6f, 1'b0};
        vecs[4]  = '{8'h6e, INC_1K,                   8'h6e, 1'b0};
        vecs[5]  = '{8'h41, INC_1K,                   8'h6e, 1'b1};
        vecs[6]  = '{8'h7a, 64'd0,                    8'h7a, 1'b0};
        vecs[7]  = '{8'h6e, 64'd0,                    8'h6e, 1'b0};
        vecs[8]  = '{8'h6f, 64'd0,                    8'h6f, 1'b0};
        vecs[9]  = '{8'h67, INC_15K,                  8'h67, 1'b0};
        vecs[10] = '{8'h66, INC_10K,                  8'h66, 1'b0};
        vecs[11] = '{8'h62, INC_5K,                   8'h62, 1'b0};

        prev = 64'd0;
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].b);
            chk($sformatf("vec%0d_err", i), {63'd0, bus_if.cmd_err}, {63'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d_hold", i), bus_if.phase_inc, prev);
            idle(1);
            chk($sformatf("vec%0d_err_low", i), {63'd0, bus_if.cmd_err}, 64'd0);
            strobe();
            chk($sformatf("vec%0d_phase", i), bus_if.phase_inc, vecs[i].exp_phase);
            chk($sformatf("vec%0d_last", i), {56'd0, bus_if.last_cmd}, {56'd0, vecs[i].exp_last});
            prev = vecs[i].exp_phase;
        end
        m_target = INC_5K;
        m_last   = 8'h62;

        // Upward saturation.
        send(8'h67);
        e = model_cmd(8'h67);
        for (int i = 0; i < 20; i++) begin
            send(8'h6d);
            e = model_cmd(8'h6d);
            strobe();
            chk($sformatf("sat_m%0d", i), bus_if.phase_inc, m_target);
        end
        chk("sat_max", bus_if.phase_inc, 64'd5902958103587056517);

        // Command and strobe on the same edge.
        send_ce(8'h62, 1'b1);
        e = model_cmd(8'h62);
        chk("same_edge_old", bus_if.phase_inc, INC_MAX);
        idle(2);
        strobe();
        chk("same_edge_new", bus_if.phase_inc, INC_5K);

        // Raw loads.
        raw_load(64'h0000_0000_0000_1000, 1'b1);
        strobe();
        chk("raw_1000", bus_if.phase_inc, 64'h1000);
        chk("raw_last", {56'd0, bus_if.last_cmd}, 64'h78);
        raw_load(64'hffff_ffff_ffff_ffff, 1'b1);
        strobe();
        chk("raw_clamp", bus_if.phase_inc, INC_MAX);
        raw_load(64'h0000_0000_0000_1000, 1'b0);

        // Load timeout after five bytes.
        send(8'h78);
        for (int i = 0; i < 5; i++) send(8'hab);
        idle(TMO - 1);
        chk("tmo_busy_before", {63'd0, bus_if.busy}, 64'd1);
        chk("tmo_err_before", {63'd0, bus_if.cmd_err}, 64'd0);
        idle(1);
        chk("tmo_busy_after", {63'd0, bus_if.busy}, 64'd0);
        chk("tmo_err_pulse", {63'd0, bus_if.cmd_err}, 64'd1);
        idle(1);
        chk("tmo_err_low", {63'd0, bus_if.cmd_err}, 64'd0);
        strobe();
        chk("tmo_target_kept", bus_if.phase_inc, 64'h1000);
        send(8'h70);
        e = model_cmd(8'h70);
        strobe();
        chk("tmo_then_cmd", bus_if.phase_inc, 64'h1000 + INC_100);

`ifndef NCO_SWEEP_EN
        send(8'h73);
        chk("s_unknown_err", {63'd0, bus_if.cmd_err}, 64'd1);
        chk("s_unknown_last", {56'd0, bus_if.last_cmd}, 64'h70);
`endif

        // Randomized commands against the model.
        cmds = "abfgmnopz";
        for (int it = 0; it < 200; it++) begin
            case ($urandom_range(0, 11))
                10: begin
                    b = 8'h00;
                    while (is_cmd(b)) b = 8'($urandom_range(0, 255));
                    prev = m_target;
                    send(b);
                    e = model_cmd(b);
                    chk("rnd_unknown_err", {63'd0, bus_if.cmd_err}, 64'd1);
                end
                11: begin
                    rv = {32'($urandom), 32'($urandom)};
                    if ($urandom_range(0, 1) == 1) rv = rv % INC_MAX;
                    raw_load(rv, 1'b0);
                end
                default: begin
                    b = cmds[$urandom_range(0, 8)];
                    prev = m_target;
                    ce = ($urandom_range(0, 3) == 0);
                    send_ce(b, ce);
                    e = model_cmd(b);
                    if (ce) chk("rnd_same_edge", bus_if.phase_inc, prev);
                    chk("rnd_err", {63'd0, bus_if.cmd_err}, 64'd0);
                end
            endcase
            idle($urandom_range(0, 2));
            strobe();
            chk("rnd_phase", bus_if.phase_inc, m_target);
            chk("rnd_last", {56'd0, bus_if.last_cmd}, {56'd0, m_last});
        end

        // Reset in the middle of a load.
        send(8'h61);
        strobe();
        send(8'h78);
        send(8'h12);
        send(8'h34);
        #2 arst_n = 1'b0;
        #1;
        chk("arst_phase", bus_if.phase_inc, 64'd0);
        chk("arst_busy", {63'd0, bus_if.busy}, 64'd0);
        chk("arst_last", {56'd0, bus_if.last_cmd}, 64'd0);
        chk("arst_err", {63'd0, bus_if.cmd_err}, 64'd0);
        idle(2);
        arst_n = 1'b1;
        idle(1);
        send(8'h70);
        strobe();
        chk("post_rst_phase", bus_if.phase_inc, INC_100);
        chk("post_rst_last", {56'd0, bus_if.last_cmd}, 64'h70);
        chk("post_rst_busy", {63'd0, bus_if.busy}, 64'd0);

`ifdef NCO_SWEEP_EN
        send(8'h61);
        send(8'h73);
        chk("sweep_last", {56'd0, bus_if.last_cmd}, 64'h73);
        chk("sweep_err", {63'd0, bus_if.cmd_err}, 64'd0);
        for (int i = 0; i < SDIV; i++) strobe();
        chk("sweep_before_step", bus_if.phase_inc, INC_1K);
        strobe();
        chk("sweep_step", bus_if.phase_inc, INC_1K + INC_100);
        raw_load(INC_MAX - 64'd50, 1'b0);
        send(8'h73);
        for (int i = 0; i < SDIV; i++) strobe();
        chk("sweep_near_max", bus_if.phase_inc, INC_MAX - 64'd50);
        strobe();
        chk("sweep_sawtooth", bus_if.phase_inc, INC_100);
        send(8'h7a);
        for (int i = 0; i < 2 * SDIV + 2; i++) strobe();
        chk("sweep_z_stops", bus_if.phase_inc, 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nco_freq_ctrl.md
# nco_freq_ctrl

Command-driven frequency controller for the sine NCO feeding the I2S DAC path. It decodes received UART bytes into a target phase increment: presets, saturating ±1 kHz/±100 Hz steps, mute, and raw 64-bit loads. It commits the target to the NCO only on sample-strobe boundaries, so a frequency change never lands mid-sample. An optional sweep mode steps the frequency autonomously.

## Interface
Parameters:
- PHASE_WIDTH, 64, width of phase increment
- INC_100, 64'd19676527011956855, increment for 100 Hz
- INC_1K, 64'd196765270119568550, increment for 1 kHz
- INC_5K, 64'd983826350597842752, preset 'b'
- INC_10K, 64'd1967652701195685505, preset 'f'
- INC_15K, 64'd2951479051793528258, preset 'g'
- INC_MAX, 64'd5902958103587056517, upper saturation limit (30 kHz)
- TIMEOUT_CYC, 4800000, raw-load inter-byte timeout in clk cycles (100 ms at 48 MHz)
- SWEEP_DIV, 480, sample strobes per sweep step (sweep build only)

Ports:
- clk  in  1  system clock (48 MHz PLL output)
- arst_n  in  1  asynchronous active-low reset
- sample_ce  in  1  one-cycle sample strobe from DAC serializer
- rx_valid  in  1  one-cycle byte-valid from UART RX
- rx_byte  in  8  received byte
- phase_inc  out  PHASE_WIDTH  committed increment to NCO
- busy  out  1  high while in LOAD state
- cmd_err  out  1  one-cycle pulse on unknown byte or load timeout
- last_cmd  out  8  last accepted command byte (LED display)

## Operation
- Internal `target` register (PHASE_WIDTH). All arithmetic operates on `target`, not `phase_inc`, so back-to-back commands accumulate.
- State machine: IDLE, LOAD. A `sweep` flag exists in the sweep build only.
- IDLE, on rx_valid:
  - 'a' loads INC_1K; 'b' loads INC_5K; 'f' loads INC_10K; 'g' loads INC_15K.
  - 'm'/'n' apply +INC_1K / −INC_1K. 'p'/'o' apply +INC_100 / −INC_100.
  - 'z' sets target to 0.
  - 'x' clears the byte counter and enters LOAD.
  - Any other byte: target unchanged, cmd_err pulse, last_cmd unchanged.
  - Every accepted command, including 'x', updates last_cmd.
- Saturating arithmetic: an add whose result exceeds INC_MAX (or overflows PHASE_WIDTH) yields INC_MAX. A subtract whose result goes below 0 yields 0. No wrap-around.
- LOAD:
  - Each rx_valid shifts rx_byte into a shadow register, MSB first.
  - After the 8th byte: target is set to min(shadow, INC_MAX), then return to IDLE.
  - No byte within TIMEOUT_CYC cycles of the previous one: abort to IDLE, pulse cmd_err, target unchanged.
  - Bytes in LOAD are data, never commands.
- Commit: on every clk edge with sample_ce=1, phase_inc <= target.
- Reset (arst_n low, asynchronous): phase_inc=0, target=0, state=IDLE, busy=0, cmd_err=0, last_cmd=0, sweep=0, all counters 0. Assertion in the middle of a LOAD discards the partial shadow.

## Timing
- rx_valid sampled at edge N: target updated at edge N. cmd_err (if any) is high for cycle N+1 only.
- phase_inc follows at the first edge ≥ N+1 with sample_ce=1.
- rx_valid and sample_ce at the same edge: phase_inc takes the pre-command target; the new value commits at the next strobe.
- busy rises the cycle after 'x' is accepted. It falls the cycle after the 8th byte or after the timeout.
- Timeout counter resets on each LOAD byte. Abort occurs exactly TIMEOUT_CYC cycles after the last byte.
- Maximum latency from byte to NCO is one sample period plus 1 cycle.

## Configuration
- NCO_SWEEP_EN defined:
  - IDLE byte 's' toggles the sweep flag.
  - While sweep=1, every SWEEP_DIV sample strobes target += INC_100. A result above INC_MAX reloads INC_100 (sawtooth).
  - Any other accepted command clears sweep and is applied normally.
  - A sweep step and an rx command at the same edge: the command wins, and the sweep step is dropped.
- NCO_SWEEP_EN undefined:
  - 's' is an unknown byte (cmd_err pulse).
  - No sweep flag or divider counter is present.

## Test plan
- Reset, then 'a' with sample_ce every 1000 cycles: phase_inc = 0 until the first strobe after the byte, then 196765270119568550. last_cmd=0x61.
- 'g', then 'm' ×20: target saturates at INC_MAX = 5902958103587056517 and does not wrap. 'n' from 0 leaves target 0.
- 'x' then bytes 00 00 00 00 00 00 10 00: busy high for 8 bytes, then target = 64'h1000. With 5 bytes followed by an idle gap of TIMEOUT_CYC cycles: cmd_err pulse, target unchanged, busy=0.
- rx_valid('b') in the same cycle as sample_ce: phase_inc keeps its old value that strobe and becomes INC_5K at the next strobe.
- Byte 0x41 ('A'): one-cycle cmd_err, target and last_cmd unchanged. arst_n low mid-LOAD: all outputs 0 immediately.
- NCO_SWEEP_EN build: 'a', 's', then SWEEP_DIV strobes: target = INC_1K + INC_100. Approaching INC_MAX, the target wraps to INC_100. A 'z' clears sweep and sets target to 0.
